// File: rtl/poly_note_pkg.sv
// Shared constants and command layout for the polyphonic note player.
package poly_note_pkg;

  localparam int unsigned NUM_CH_DEF   = 4;
  localparam int unsigned CNT_W_DEF    = 21;
  localparam int unsigned DUR_W_DEF    = 16;
  localparam int unsigned TICK_DIV_DEF = 50000;

  // Channel select carries one extra bit so out-of-range targets are visible.
  localparam int unsigned CH_W  = $clog2(NUM_CH_DEF) + 1;
  localparam int unsigned MIX_W = $clog2(NUM_CH_DEF + 1);

  typedef struct packed {
    logic [CH_W-1:0]      ch;
    logic [CNT_W_DEF-1:0] half;
    logic [DUR_W_DEF-1:0] dur;
  } note_cmd_t;

endpackage

// File: rtl/note_channel.sv
// One square-wave tone channel with optional auto-release duration.
module note_channel #(
  parameter int unsigned CNT_W = 21,
  parameter int unsigned DUR_W = 16
) (
  input  logic             iClk,
  input  logic             iReset,
  input  logic             iLoad,
  input  logic [CNT_W-1:0] iCmdHalf,
  input  logic [DUR_W-1:0] iCmdDur,
  input  logic             iTick,
  input  logic             iPause,
  output logic             oNote,
  output logic             oBusy,
  output logic             oDone
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half;
  logic [DUR_W-1:0] rem;
  logic             expire;

  // Duration runs out on this tick; rem == 0 means sustain forever.
  assign expire = iTick && (rem == DUR_W'(1));

  // Load has priority over tone stepping and expiry; pause freezes everything else.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      cnt   <= CNT_W'(1);
      half  <= '0;
      rem   <= '0;
      oNote <= 1'b0;
      oBusy <= 1'b0;
      oDone <= 1'b0;
    end else begin
      oDone <= 1'b0;
      if (iLoad) begin
        cnt   <= CNT_W'(1);
        oNote <= 1'b0;
        oBusy <= (iCmdHalf != '0);
        if (iCmdHalf != '0) begin
          half <= iCmdHalf;
          rem  <= iCmdDur;
        end
      end else if (oBusy && !iPause) begin
        if (expire) begin
          cnt   <= CNT_W'(1);
          oNote <= 1'b0;
          oBusy <= 1'b0;
          oDone <= 1'b1;
        end else begin
          if (iTick && (rem != '0)) begin
            rem <= rem - DUR_W'(1);
          end
          if (cnt < half) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            cnt   <= CNT_W'(1);
            oNote <= ~oNote;
          end
        end
      end
    end
  end

endmodule

// File: rtl/poly_note_player.sv
// Multi-channel square-wave note player with command port and popcount mix.
module poly_note_player
  import poly_note_pkg::*;
#(
  parameter int unsigned NUM_CH   = NUM_CH_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned DUR_W    = DUR_W_DEF,
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input  logic                           iClk,
  input  logic                           iReset,
  input  logic                           iLoadValid,
  output logic                           oLoadReady,
  input  logic [$clog2(NUM_CH):0]        iLoadCh,
  input  logic [CNT_W-1:0]               iLoadHalfPeriod,
  input  logic [DUR_W-1:0]               iLoadDuration,
  input  logic                           iPause,
  output logic [NUM_CH-1:0]              oNote,
  output logic [NUM_CH-1:0]              oBusy,
  output logic [NUM_CH-1:0]              oDone,
  output logic [$clog2(NUM_CH+1)-1:0]    oMix,
  output logic                           oErr
);

  localparam int unsigned CH_BITS  = $clog2(NUM_CH) + 1;
  localparam int unsigned MIX_BITS = $clog2(NUM_CH + 1);
  localparam int unsigned PRE_W    = $clog2(TICK_DIV);

  logic [PRE_W-1:0]    preCnt;
  logic                tick;
  logic                accept;
  logic                chInRange;
  logic [NUM_CH-1:0]   loadCh;
  logic [MIX_BITS-1:0] popCount;

  assign accept    = iLoadValid && oLoadReady;
  assign chInRange = (iLoadCh < CH_BITS'(NUM_CH));
  assign tick      = !iPause && (preCnt == PRE_W'(TICK_DIV - 1));

  // Free-running duration prescaler; held while paused, never touched by loads.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      preCnt <= '0;
    end else if (!iPause) begin
      preCnt <= tick ? '0 : preCnt + PRE_W'(1);
    end
  end

  // Ready comes up on the first edge out of reset; errors flag out-of-range commands.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      oLoadReady <= 1'b0;
      oErr       <= 1'b0;
    end else begin
      oLoadReady <= 1'b1;
      oErr       <= accept && !chInRange;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : gCh
    assign loadCh[gi] = accept && (iLoadCh == CH_BITS'(gi));

    note_channel #(
      .CNT_W (CNT_W),
      .DUR_W (DUR_W)
    ) uChannel (
      .iClk     (iClk),
      .iReset   (iReset),
      .iLoad    (loadCh[gi]),
      .iCmdHalf (iLoadHalfPeriod),
      .iCmdDur  (iLoadDuration),
      .iTick    (tick),
      .iPause   (iPause),
      .oNote    (oNote[gi]),
      .oBusy    (oBusy[gi]),
      .oDone    (oDone[gi])
    );
  end

  // Count of channels currently high.
  always_comb begin
    popCount = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      popCount = popCount + MIX_BITS'(oNote[i]);
    end
  end

  // Registered mix for the DAC/PWM stage.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      oMix <= '0;
    end else begin
      oMix <= popCount;
    end
  end

endmodule

// File: tb/tb_poly_note_player.sv
// Self-checking bench for poly_note_player against a behavioural model.
module tb_poly_note_player;
  import poly_note_pkg::*;

  localparam int NCH  = 4;
  localparam int TDIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic       pause = 1'b0;
  note_cmd_t  cmd = '0;
  logic       loadReady;
  logic [3:0] note, busy, done;
  logic [2:0] mix;
  logic       err;

  int total = 0;
  int bad   = 0;
  bit chkEn = 1'b0;

  always #5 clk = ~clk;

  poly_note_player #(
    .NUM_CH   (NCH),
    .CNT_W    (CNT_W_DEF),
    .DUR_W    (DUR_W_DEF),
    .TICK_DIV (TDIV)
  ) dut (
    .iClk            (clk),
    .iReset          (rst),
    .iLoadValid      (valid),
    .oLoadReady      (loadReady),
    .iLoadCh         (cmd.ch),
    .iLoadHalfPeriod (cmd.half),
    .iLoadDuration   (cmd.dur),
    .iPause          (pause),
    .oNote           (note),
    .oBusy           (busy),
    .oDone           (done),
    .oMix            (mix),
    .oErr            (err)
  );

  // Behavioural model: a sounding channel's level is parity of (active edges since load / H);
  // it expires on the D-th global tick seen while sounding.
  bit       mBusy [NCH];
  int       mE    [NCH];
  int       mH    [NCH];
  int       mD    [NCH];
  int       mT    [NCH];
  bit [3:0] mNote = '0;
  bit [3:0] mDone = '0;
  int       mMix  = 0;
  bit       mErr  = 1'b0;
  bit       mReady = 1'b0;
  int       mG    = 0;

  always @(posedge clk) begin
    bit       acc, tk;
    bit [3:0] prev;
    prev = mNote;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        mBusy[i] = 1'b0; mE[i] = 0; mH[i] = 1; mD[i] = 0; mT[i] = 0;
      end
      mNote = '0; mDone = '0; mMix = 0; mErr = 1'b0; mReady = 1'b0; mG = 0;
    end else begin
      acc = valid && mReady;
      tk  = !pause && (((mG + 1) % TDIV) == 0);
      if (!pause) mG++;
      mErr  = acc && (int'(cmd.ch) >= NCH);
      mDone = '0;
      for (int i = 0; i < NCH; i++) begin
        if (acc && (int'(cmd.ch) == i)) begin
          if (cmd.half != '0) begin
            mBusy[i] = 1'b1; mE[i] = 0; mH[i] = int'(cmd.half);
            mD[i] = int'(cmd.dur); mT[i] = 0;
          end else begin
            mBusy[i] = 1'b0;
          end
        end else if (mBusy[i] && !pause) begin
          mE[i]++;
          if (tk && mD[i] != 0) begin
            mT[i]++;
            if (mT[i] == mD[i]) begin
              mBusy[i] = 1'b0;
              mDone[i] = 1'b1;
            end
          end
        end
        mNote[i] = mBusy[i] && (((mE[i] / mH[i]) % 2) == 1);
      end
      mMix   = $countones(prev);
      mReady = 1'b1;
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chkEn) begin
      chk("note",  int'(note),      int'(mNote));
      chk("busy",  int'(busy),      int'(mBusy[0]) | int'(mBusy[1]) << 1 |
                                    int'(mBusy[2]) << 2 | int'(mBusy[3]) << 3);
      chk("done",  int'(done),      int'(mDone));
      chk("mix",   int'(mix),       mMix);
      chk("err",   int'(err),       int'(mErr));
      chk("ready", int'(loadReady), int'(mReady));
    end
  end

  task automatic load(input int c, input int h, input int d);
    cmd.ch   = CH_W'(c);
    cmd.half = CNT_W_DEF'(h);
    cmd.dur  = DUR_W_DEF'(d);
    valid    = 1'b1;
    @(negedge clk);
    valid    = 1'b0;
  endtask

  initial begin
    bit [6:0] pat1;
    bit [4:0] pat3;
    int       pulses;
    int       waitCnt;

    pat1 = 7'b0111000;
    pat3 = 5'b01100;

    repeat (3) @(negedge clk);
    chkEn = 1'b1;
    chk("rst_ready", int'(loadReady), 0);
    chk("rst_busy",  int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_up", int'(loadReady), 1);

    // 1: ch0 H=3 sustained
    load(0, 3, 0);
    for (int k = 0; k < 7; k++) begin
      chk("t1_pat", int'(note[0]), int'(pat1[k]));
      chk("t1_busy", int'(busy[0]), 1);
      if (k == 4) chk("t1_mix", int'(mix), 1);
      if (k < 6) @(negedge clk);
    end
    load(0, 0, 0);

    // 2: ch1 H=2 D=3 auto-release
    load(1, 2, 3);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      if (done[1]) pulses++;
      @(negedge clk);
    end
    chk("t2_done_cnt", pulses, 1);
    chk("t2_busy", int'(busy[1]), 0);
    chk("t2_note", int'(note[1]), 0);

    // 3: retrigger mid-high, then stop
    load(2, 5, 0);
    waitCnt = 0;
    while (note[2] != 1'b1 && waitCnt < 12) begin
      @(negedge clk);
      waitCnt++;
    end
    chk("t3_rise_seen", int'(note[2]), 1);
    repeat (2) @(negedge clk);
    load(2, 2, 0);
    for (int k = 0; k < 5; k++) begin
      chk("t3_pat", int'(note[2]), int'(pat3[k]));
      if (k < 4) @(negedge clk);
    end
    load(2, 0, 0);
    chk("t3_stop_busy", int'(busy[2]), 0);
    chk("t3_stop_done", int'(done[2]), 0);

    // 4: all channels H=1 loaded in phase under pause
    pause = 1'b1;
    for (int i = 0; i < NCH; i++) load(i, 1, 0);
    pause = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t4_mix", int'(mix), (k % 2 == 1) ? 4 : 0);
    end
    pause = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_frozen", int'(note), 0);
    end
    pause = 1'b0;
    @(negedge clk);
    chk("t4_resume", int'(note), 15);
    for (int i = 0; i < NCH; i++) load(i, 0, 0);

    // 5: out-of-range channel, then load on the expiry tick
    load(NCH, 3, 0);
    chk("t5_err", int'(err), 1);
    chk("t5_err_busy", int'(busy), 0);
    @(negedge clk);
    chk("t5_err_clr", int'(err), 0);
    load(3, 3, 1);
    waitCnt = 0;
    while (((mG + 1) % TDIV) != 0 && waitCnt < 8) begin
      @(negedge clk);
      waitCnt++;
    end
    chk("t5_busy_before", int'(busy[3]), 1);
    load(3, 4, 0);
    chk("t5_no_done", int'(done[3]), 0);
    chk("t5_load_wins", int'(busy[3]), 1);
    load(3, 0, 0);

    // 6: reset mid-note, then random traffic
    load(0, 2, 0);
    load(1, 3, 0);
    load(2, 4, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_note", int'(note), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_done", int'(done), 0);
    chk("t6_ready", int'(loadReady), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_ready_up", int'(loadReady), 1);

    for (int k = 0; k < 600; k++) begin
      valid    = ($urandom % 3) == 0;
      cmd.ch   = CH_W'($urandom_range(0, 4));
      cmd.half = CNT_W_DEF'($urandom_range(0, 6));
      cmd.dur  = DUR_W_DEF'($urandom_range(0, 5));
      pause    = ($urandom % 10) == 0;
      rst      = ($urandom % 200) == 0;
      @(negedge clk);
    end
    valid = 1'b0;
    pause = 1'b0;
    rst   = 1'b0;
    repeat (4) @(negedge clk);
    chkEn = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
